hmm_frame_decision: RTL and testbench

- Consumes the per-state log-likelihood stream of the silence HMM scorer (one signed 64-bit score per state, tagged with its state index) and produces one decision per frame.
- Per frame it finds the best-scoring state (argmax) and compares the best score against a silence threshold.
- It then applies an on/off hangover counter to give a debounced silence flag to the downstream segmentation logic.
- Sits directly downstream of the HMM scorer, driven by its dv/out_index/x_o/done outputs.

---
 rtl/hmm_frame_decision.sv | 191 +++++++++++++++++++
 tb/tb_hmm_frame_decision.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hmm_frame_decision.sv
// hmm_frame_decision
// Per-frame argmax over the HMM scorer's per-state log-likelihoods, a raw
// silence decision against THRESH, and an on/off hangover that debounces the
// decision into sil_flag for the segmentation logic.
module hmm_frame_decision #(
    parameter int                 STATE   = 12,
    parameter logic signed [63:0] THRESH  = 64'sd0,
    parameter int                 ON_CNT  = 3,
    parameter int                 OFF_CNT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dv_i,
    input  logic [15:0] index_i,
    input  logic [63:0] score_i,
    input  logic        done_i,
    output logic        frame_dv,
    output logic [15:0] best_index,
    output logic [63:0] best_score,
    output logic        sil_frame,
    output logic        sil_flag,
    output logic [15:0] frame_cnt,
    output logic        err
);

    localparam logic signed [63:0] MOST_NEG  = 64'sh8000_0000_0000_0000;
    localparam logic [15:0]        NO_INDEX  = 16'hFFFF;
    localparam logic [15:0]        STATE_N   = 16'(STATE);
    localparam logic [15:0]        ON_LIM    = 16'(ON_CNT);
    localparam logic [15:0]        OFF_LIM   = 16'(OFF_CNT);
    localparam logic [15:0]        CNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DECIDE  = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
        return (v >= lim) ? lim : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic               done_q;
    logic [15:0]        cnt_q, cnt_d;
    logic signed [63:0] max_q, max_d;
    logic [15:0]        idx_q, idx_d;
    logic [15:0]        on_q, on_d;
    logic [15:0]        off_q, off_d;
    logic [15:0]        best_index_q, best_index_d;
    logic signed [63:0] best_score_q, best_score_d;
    logic               sil_frame_q, sil_frame_d;
    logic               sil_flag_q, sil_flag_d;
    logic               frame_dv_q, frame_dv_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;

    logic signed [63:0] score_s;
    logic               done_rise;
    logic               is_sil;

    assign score_s   = score_i;
    assign done_rise = done_i & ~done_q;

    // Register all state; reset discards any partially collected frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            done_q       <= 1'b0;
            cnt_q        <= 16'd0;
            max_q        <= MOST_NEG;
            idx_q        <= NO_INDEX;
            on_q         <= 16'd0;
            off_q        <= 16'd0;
            best_index_q <= 16'd0;
            best_score_q <= 64'sd0;
            sil_frame_q  <= 1'b0;
            sil_flag_q   <= 1'b0;
            frame_dv_q   <= 1'b0;
            frame_cnt_q  <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_i;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
            on_q         <= on_d;
            off_q        <= off_d;
            best_index_q <= best_index_d;
            best_score_q <= best_score_d;
            sil_frame_q  <= sil_frame_d;
            sil_flag_q   <= sil_flag_d;
            frame_dv_q   <= frame_dv_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic: collect scores, decide once per frame, then publish.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        idx_d        = idx_q;
        on_d         = on_q;
        off_d        = off_q;
        best_index_d = best_index_q;
        best_score_d = best_score_q;
        sil_frame_d  = sil_frame_q;
        sil_flag_d   = sil_flag_q;
        frame_dv_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        is_sil       = 1'b0;

        case (state_q)
            COLLECT: begin
                if (dv_i) begin
                    // Strict compare: on a tie the earliest arrival is kept.
                    if (score_s > max_q) begin
                        max_d = score_s;
                        idx_d = index_i;
                    end
                    cnt_d = sat_inc(cnt_q, CNT_MAX);
                    if (index_i != cnt_q) begin
                        err_d = 1'b1;
                    end
                end
                // A score arriving with the done edge is already folded in above.
                if (done_rise) begin
                    state_d = DECIDE;
                end
            end

            DECIDE: begin
                if (dv_i) begin
                    err_d = 1'b1;
                end
                // An empty frame never counts as silence, whatever THRESH is.
                is_sil       = (cnt_q != 16'd0) && (max_q >= THRESH);
                best_index_d = idx_q;
                best_score_d = max_q;
                sil_frame_d  = is_sil;
                if (cnt_q != STATE_N) begin
                    err_d = 1'b1;
                end
                if (is_sil) begin
                    off_d = 16'd0;
                    on_d  = sat_inc(on_q, ON_LIM);
                    if (on_d == ON_LIM) begin
                        sil_flag_d = 1'b1;
                    end
                end else begin
                    on_d  = 16'd0;
                    off_d = sat_inc(off_q, OFF_LIM);
                    if (off_d == OFF_LIM) begin
                        sil_flag_d = 1'b0;
                    end
                end
                state_d = OUT;
            end

            OUT: begin
                if (dv_i) begin
                    err_d = 1'b1;
                end
                frame_dv_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                cnt_d       = 16'd0;
                max_d       = MOST_NEG;
                idx_d       = NO_INDEX;
                state_d     = COLLECT;
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign frame_dv   = frame_dv_q;
    assign best_index = best_index_q;
    assign best_score = best_score_q;
    assign sil_frame  = sil_frame_q;
    assign sil_flag   = sil_flag_q;
    assign frame_cnt  = frame_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hmm_frame_decision.sv
// Testbench for hmm_frame_decision: table of frames with hand-computed
// decisions, plus directed sequences for reset, index skips and empty frames.
module tb_hmm_frame_decision;

    logic        clk = 1'b0;
    logic        reset;
    logic        dv_i;
    logic [15:0] index_i;
    logic [63:0] score_i;
    logic        done_i;
    logic        frame_dv;
    logic [15:0] best_index;
    logic [63:0] best_score;
    logic        sil_frame;
    logic        sil_flag;
    logic [15:0] frame_cnt;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    hmm_frame_decision #(
        .STATE(12), .THRESH(64'sd0), .ON_CNT(3), .OFF_CNT(5)
    ) dut (
        .clk(clk), .reset(reset), .dv_i(dv_i), .index_i(index_i),
        .score_i(score_i), .done_i(done_i), .frame_dv(frame_dv),
        .best_index(best_index), .best_score(best_score),
        .sil_frame(sil_frame), .sil_flag(sil_flag),
        .frame_cnt(frame_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          hi_idx;
        longint      hi_val;
        int          tie_idx;
        longint      fill;
        logic [15:0] e_idx;
        longint      e_score;
        logic        e_sil;
        logic        e_flag;
        logic [15:0] e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one frame, raises done (with the last score when simul is set),
    // waits for frame_dv and checks the decision; skip_at>=0 skips an index.
    task automatic send_frame(input vec_t v, input bit simul, input int skip_at);
        int lat;
        for (int i = 0; i < v.n; i++) begin
            dv_i    = 1'b1;
            index_i = 16'((skip_at >= 0 && i >= skip_at) ? i + 1 : i);
            score_i = (i == v.hi_idx || i == v.tie_idx) ? 64'(v.hi_val) : 64'(v.fill - i);
            if (simul && i == v.n - 1) done_i = 1'b1;
            tick();
        end
        dv_i = 1'b0;
        if (!(simul && v.n > 0)) begin
            done_i = 1'b1;
            tick();
        end
        lat = 0;
        while (!frame_dv && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd2);
        chk("best_index", 64'(best_index), 64'(v.e_idx));
        chk("best_score", best_score, 64'(v.e_score));
        chk("sil_frame", 64'(sil_frame), 64'(v.e_sil));
        chk("sil_flag", 64'(sil_flag), 64'(v.e_flag));
        chk("frame_cnt", 64'(frame_cnt), 64'(v.e_cnt));
        chk("err", 64'(err), 64'(v.e_err));
        // done stays high: no further decision may appear.
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_redecide", 64'(frame_dv), 64'd0);
        end
        done_i = 1'b0;
        tick();
    endtask

    initial begin
        vec_t v;
        //           n  hi  hi_val tie  fill   e_idx e_score e_sil flag cnt err
        vecs[0] = '{12,  7,  500,  -1,   -50,   7,   500,  1, 0,  1, 0};
        vecs[1] = '{12,  3,    0,  -1,   -20,   3,     0,  1, 0,  2, 0};
        vecs[2] = '{12, 11,    1,  -1,    -5,  11,     1,  1, 1,  3, 0};
        vecs[3] = '{12,  2,   -7,   9, -1000,   2,    -7,  0, 1,  4, 0};
        vecs[4] = '{12,  0,   -1,  -1,  -100,   0,    -1,  0, 1,  5, 0};
        vecs[5] = '{12,  5,   -2,  -1,   -30,   5,    -2,  0, 1,  6, 0};
        vecs[6] = '{12,  6,   -9,  -1,   -60,   6,    -9,  0, 1,  7, 0};
        vecs[7] = '{12,  8,   -4,  -1,   -40,   8,    -4,  0, 0,  8, 0};
        vecs[8] = '{10,  4,   77,  -1,   -10,   4,    77,  1, 0,  9, 1};
        vecs[9] = '{12, 10,  123,  -1,   -10,  10,   123,  1, 0, 10, 1};

        // Reset with random inputs.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dv_i    = 1'($urandom);
            index_i = 16'($urandom);
            score_i = {$urandom, $urandom};
            done_i  = 1'($urandom);
            tick();
        end
        chk("rst_frame_dv", 64'(frame_dv), 64'd0);
        chk("rst_best_index", 64'(best_index), 64'd0);
        chk("rst_best_score", best_score, 64'd0);
        chk("rst_sil_frame", 64'(sil_frame), 64'd0);
        chk("rst_sil_flag", 64'(sil_flag), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        dv_i = 1'b0; index_i = 16'd0; score_i = 64'd0; done_i = 1'b0;
        reset = 1'b0;
        tick();

        // Table: argmax, ties, threshold boundary, hangover, count errors.
        for (int t = 0; t < 10; t++) begin
            send_frame(vecs[t], 1'b0, -1);
        end

        // Index skip 4->6 on an otherwise full frame.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        v = '{12, 2, 3, -1, -10, 2, 3, 1, 0, 1, 1};
        send_frame(v, 1'b0, 5);

        // Partial frame discarded by reset, then last score coincides with done edge.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            dv_i = 1'b1; index_i = 16'(i);
            score_i = (i == 1) ? 64'd9999 : 64'd5;
            tick();
        end
        dv_i = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        v = '{12, 11, 42, -1, -500, 11, 42, 1, 0, 1, 0};
        send_frame(v, 1'b1, -1);

        // Empty frame: done edge with no scores.
        v = '{0, -1, 0, -1, 0, 16'hFFFF, 64'sh8000_0000_0000_0000, 0, 0, 2, 1};
        send_frame(v, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
